// File: rtl/ct_f_spsram_4096x32_ctrl_if.sv
// Request/response channel plus SRAM macro pins for the 4096x32 controller.
`timescale 1ns/1ps
interface ct_f_spsram_4096x32_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                    req_vld;
  logic                    req_rdy;
  logic                    req_wr;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_vld;
  logic                    rsp_rdy;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    init_done;
  logic [ADDR_WIDTH-1:0]   A;
  logic                    CEN;
  logic                    GWEN;
  logic [DATA_WIDTH-1:0]   WEN;
  logic [DATA_WIDTH-1:0]   D;
  logic [DATA_WIDTH-1:0]   Q;

  // Controller side: accepts requests, drives the macro, returns responses.
  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy, Q,
    output req_rdy, rsp_vld, rsp_rdata, init_done, A, CEN, GWEN, WEN, D
  );

  // Requester / macro side.
  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy, Q,
    input  req_rdy, rsp_vld, rsp_rdata, init_done, A, CEN, GWEN, WEN, D
  );
endinterface

// File: rtl/ct_f_spsram_4096x32_ctrl.sv
// Front end for the 4096x32 single-port SRAM macro: init sweep after reset,
// valid/ready byte-masked requests mapped to active-low macro pins, and a
// 2-entry read response buffer.
`timescale 1ns/1ps
module ct_f_spsram_4096x32_ctrl #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 32,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic CLK,
  input logic RST,
  ct_f_spsram_4096x32_ctrl_if.slave bus
);
  localparam int NB = DATA_WIDTH/8;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q;
  logic                  fire, rd_fire, push, pop;
  logic [DATA_WIDTH-1:0] wen_mask;

  // Occupancy counts the in-flight read so the buffer can never overflow;
  // a pop this cycle frees a slot for the request being accepted now.
  assign pop           = (cnt_q != 2'd0) && bus.rsp_rdy;
  assign push          = inflight_q;
  assign bus.req_rdy   = init_done_q && (state_q == S_RUN) &&
                         (({1'b0, cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign fire          = bus.req_vld && bus.req_rdy;
  assign rd_fire       = fire && !bus.req_wr;
  assign bus.rsp_vld   = (cnt_q != 2'd0);
  assign bus.rsp_rdata = buf_q[rd_ptr_q];
  assign bus.init_done = init_done_q;

  // Byte enables expanded to the macro's active-low per-bit write enable.
  always_comb begin
    wen_mask = '1;
    for (int i = 0; i < NB; i++) wen_mask[8*i +: 8] = {8{~bus.req_be[i]}};
  end

  // Sweep counter walks every address once, then hands over to RUN.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      S_INIT: begin
        init_cnt_d = init_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (&init_cnt_q) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end
      end
      S_RUN:   init_done_d = 1'b1;
      default: state_d = S_INIT;
    endcase
  end

  // Macro pins: idle under reset, sweep writes in INIT, request-driven in RUN.
  always_comb begin
    bus.CEN  = 1'b1;
    bus.GWEN = 1'b1;
    bus.WEN  = '1;
    bus.A    = '0;
    bus.D    = '0;
    if (!RST) begin
      if (state_q == S_INIT) begin
        bus.CEN  = 1'b0;
        bus.GWEN = 1'b0;
        bus.WEN  = '0;
        bus.A    = init_cnt_q;
        bus.D    = INIT_VALUE;
      end else if (fire) begin
        bus.CEN = 1'b0;
        bus.A   = bus.req_addr;
        if (bus.req_wr) begin
          bus.GWEN = 1'b0;
          bus.WEN  = wen_mask;
          bus.D    = bus.req_wdata;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= INIT_EN ? S_INIT : S_RUN;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Read pipeline and response FIFO; Q is only valid the cycle after a read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      inflight_q <= rd_fire;
      if (push) begin
        buf_q[wr_ptr_q] <= bus.Q;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule
